// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer test pattern writer.
// Pattern codes, Wishbone burst tags and the colour bar palette.
package fb_pkg;

   typedef enum logic [1:0] {
      PatSolid    = 2'd0,
      PatBars     = 2'd1,
      PatGradient = 2'd2,
      PatChecker  = 2'd3
   } pattern_e;

   localparam logic [2:0] CtiClassic = 3'b000;
   localparam logic [2:0] CtiIncr    = 3'b010;
   localparam logic [2:0] CtiEnd     = 3'b111;
   localparam logic [1:0] BteLinear  = 2'b00;

   localparam int unsigned CoordW = 16;

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] rgb;
      unique case (idx)
         3'd0: rgb = 24'hFFFFFF;
         3'd1: rgb = 24'hFFFF00;
         3'd2: rgb = 24'h00FFFF;
         3'd3: rgb = 24'h00FF00;
         3'd4: rgb = 24'hFF00FF;
         3'd5: rgb = 24'hFF0000;
         3'd6: rgb = 24'h0000FF;
         3'd7: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/fb_pattern_writer_if.sv
// 64-bit Wishbone B3 write-burst bus between the pattern writer and the DDR2 arbiter.
interface fb_pattern_writer_if;

   logic [31:0] adr;
   logic [63:0] dat;
   logic [7:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;

   modport master (
      output adr, dat, sel, we, stb, cyc, cti, bte,
      input  ack, err
   );

   modport slave (
      input  adr, dat, sel, we, stb, cyc, cti, bte,
      output ack, err
   );

endinterface

// File: rtl/fb_pattern_pixel.sv
// Combinational pixel generator: pattern and coordinates to a 32bpp {00,R,G,B} word.
module fb_pattern_pixel
   import fb_pkg::*;
#(
   parameter int unsigned H_RES      = 1024,
   parameter logic [23:0] FILL_COLOR = 24'h0000FF
) (
   input  pattern_e          pattern_sel,
   input  logic [CoordW-1:0] x,
   input  logic              y_tile,
   output logic [31:0]       pixel
);

   localparam logic [CoordW-1:0] BarW  = CoordW'(H_RES / 8);
   localparam logic [CoordW+7:0] HResW = (CoordW + 8)'(H_RES);

   logic [2:0] bar_idx;
   logic [7:0] grey;

   always_comb begin
      bar_idx = 3'(x / BarW);
      grey    = 8'({x, 8'h00} / HResW);
      pixel   = '0;
      unique case (pattern_sel)
         PatSolid:    pixel = {8'h00, FILL_COLOR};
         PatBars:     pixel = {8'h00, bar_color(bar_idx)};
         PatGradient: pixel = {8'h00, grey, grey, grey};
         // y_tile is bit 5 of the line number: 32x32 checker squares
         PatChecker:  pixel = (x[5] ^ y_tile) ? 32'h00FF_FFFF : 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone burst master that fills the frame buffer with a test image and pulses done.
// FSM and pixel/address counters live here; pixel colour comes from two generator instances.
module fb_pattern_writer
   import fb_pkg::*;
#(
   parameter logic [31:0] BASE_ADR   = 32'h0003_C000,
   parameter int unsigned H_RES      = 1024,
   parameter int unsigned V_RES      = 768,
   parameter int unsigned BURST_LEN  = 8,
   parameter logic [23:0] FILL_COLOR = 24'h0000FF
) (
   input  logic                       wb_clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 pattern_sel,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   fb_pattern_writer_if.master        wbm
);

   localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [2:0] {StIdle, StBurst, StGap, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [CoordW-1:0] x_q, x_d;
   logic [CoordW-1:0] y_q, y_d;
   logic [BeatW-1:0]  beat_q, beat_d;
   logic [31:0]       adr_q, adr_d;
   pattern_e          pat_q, pat_d;
   logic              err_q, err_d;

   logic              in_burst;
   logic              last_in_burst;
   logic              last_in_line;
   logic              last_in_frame;
   logic [CoordW-1:0] x_odd;
   logic [31:0]       pix_lo, pix_hi;

   assign in_burst      = (state_q == StBurst);
   assign last_in_burst = (beat_q == BeatW'(BURST_LEN - 1));
   assign last_in_line  = (x_q == CoordW'(H_RES - 2));
   assign last_in_frame = last_in_line && (y_q == CoordW'(V_RES - 1));
   assign x_odd         = x_q + CoordW'(1);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      beat_d  = beat_q;
      adr_d   = adr_q;
      pat_d   = pat_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StBurst;
               x_d     = '0;
               y_d     = '0;
               beat_d  = '0;
               adr_d   = BASE_ADR;
               pat_d   = pattern_e'(pattern_sel);
               err_d   = 1'b0;
            end
         end
         StBurst: begin
            // An errored beat is not counted even when ack arrives with it
            if (wbm.err) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else if (wbm.ack) begin
               adr_d  = adr_q + 32'd8;
               beat_d = last_in_burst ? '0 : beat_q + BeatW'(1);
               if (last_in_line) begin
                  x_d = '0;
                  y_d = y_q + CoordW'(1);
               end else begin
                  x_d = x_q + CoordW'(2);
               end
               if (last_in_frame) begin
                  state_d = StDone;
               end else if (last_in_burst) begin
                  state_d = StGap;
               end
            end
         end
         StGap:   state_d = StBurst;
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (reset) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         beat_q  <= '0;
         adr_q   <= '0;
         pat_q   <= PatSolid;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         beat_q  <= beat_d;
         adr_q   <= adr_d;
         pat_q   <= pat_d;
         err_q   <= err_d;
      end
   end

   fb_pattern_pixel #(
      .H_RES      (H_RES),
      .FILL_COLOR (FILL_COLOR)
   ) u_pixel_lo (
      .pattern_sel (pat_q),
      .x           (x_q),
      .y_tile      (y_q[5]),
      .pixel       (pix_lo)
   );

   fb_pattern_pixel #(
      .H_RES      (H_RES),
      .FILL_COLOR (FILL_COLOR)
   ) u_pixel_hi (
      .pattern_sel (pat_q),
      .x           (x_odd),
      .y_tile      (y_q[5]),
      .pixel       (pix_hi)
   );

   assign busy = in_burst || (state_q == StGap);
   assign done = (state_q == StDone);
   assign err  = err_q;

   assign wbm.cyc = in_burst;
   assign wbm.stb = in_burst;
   assign wbm.we  = in_burst;
   assign wbm.sel = in_burst ? 8'hFF : 8'h00;
   assign wbm.cti = in_burst ? (last_in_burst ? CtiEnd : CtiIncr) : CtiClassic;
   assign wbm.bte = BteLinear;
   assign wbm.adr = in_burst ? adr_q : 32'h0;
   assign wbm.dat = in_burst ? {pix_hi, pix_lo} : 64'h0;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Randomized bench for fb_pattern_writer: random ack wait states, error and reset
// injection, every bus cycle compared against a pixel/address reference model.
module tb_fb_pattern_writer;

   localparam logic [31:0] BaseAdr   = 32'h0003_C000;
   localparam int          HRes      = 16;
   localparam int          VRes      = 4;
   localparam int          BurstLen  = 4;
   localparam logic [23:0] FillColor = 24'h123456;
   localparam int          Total     = HRes * VRes / 2;

   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic       wb_clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;

   fb_pattern_writer_if wbm ();

   fb_pattern_writer #(
      .BASE_ADR   (BaseAdr),
      .H_RES      (HRes),
      .V_RES      (VRes),
      .BURST_LEN  (BurstLen),
      .FILL_COLOR (FillColor)
   ) dut (
      .wb_clk      (wb_clk),
      .reset       (reset),
      .start       (start),
      .pattern_sel (pattern_sel),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .wbm         (wbm)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   function automatic logic [31:0] ref_pixel(input int pat, input int x, input int y);
      logic [7:0] g;
      case (pat)
         0: return {8'h00, FillColor};
         1: return {8'h00, BARS[x / (HRes / 8)]};
         2: begin
            g = 8'((x * 256 / HRes) % 256);
            return {8'h00, g, g, g};
         end
         default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 32'h00FF_FFFF : 32'h0;
      endcase
   endfunction

   task automatic check_idle_bus(input string tag);
      check({tag, "_cyc"}, 64'(wbm.cyc), 64'd0);
      check({tag, "_stb"}, 64'(wbm.stb), 64'd0);
      check({tag, "_adr"}, 64'(wbm.adr), 64'd0);
      check({tag, "_dat"}, wbm.dat, 64'd0);
      check({tag, "_sel"}, 64'(wbm.sel), 64'd0);
      check({tag, "_we"},  64'(wbm.we),  64'd0);
      check({tag, "_cti"}, 64'(wbm.cti), 64'd0);
   endtask

   task automatic check_beat(input int k, input int pat);
      int x;
      int y;
      x = (2 * k) % HRes;
      y = (2 * k) / HRes;
      check("beat_cyc", 64'(wbm.cyc), 64'd1);
      check("beat_stb", 64'(wbm.stb), 64'd1);
      check("beat_we",  64'(wbm.we),  64'd1);
      check("beat_sel", 64'(wbm.sel), 64'hFF);
      check("beat_bte", 64'(wbm.bte), 64'd0);
      check("beat_busy", 64'(busy), 64'd1);
      check("beat_done", 64'(done), 64'd0);
      check("beat_adr", 64'(wbm.adr), 64'(BaseAdr + 32'(8 * k)));
      check("beat_dat", wbm.dat, {ref_pixel(pat, x + 1, y), ref_pixel(pat, x, y)});
      check("beat_cti", 64'(wbm.cti), (k % BurstLen == BurstLen - 1) ? 64'd7 : 64'd2);
   endtask

   // Drives one frame; err_beat/rst_beat < 0 disables that injection.
   task automatic run_frame(input int pat, input int max_wait, input int err_beat,
                            input int rst_beat, input bit poke);
      int k = 0;
      int wait_left;
      bit poked = 1'b0;
      @(negedge wb_clk);
      start = 1'b1;
      pattern_sel = 2'(pat);
      @(negedge wb_clk);
      start = 1'b0;
      check("busy_on_start", 64'(busy), 64'd1);
      check("err_clear_on_start", 64'(err), 64'd0);
      wait_left = $urandom_range(max_wait, 0);
      while (k < Total) begin
         check_beat(k, pat);
         if (k == rst_beat) begin
            reset = 1'b1;
            @(negedge wb_clk);
            reset = 1'b0;
            check_idle_bus("rst");
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_err", 64'(err), 64'd0);
            repeat (6) begin
               @(negedge wb_clk);
               check("rst_no_done", 64'(done), 64'd0);
               check("rst_no_cyc", 64'(wbm.cyc), 64'd0);
            end
            return;
         end
         if (poke && k == 5 && !poked) begin
            start = 1'b1;
            pattern_sel = 2'(pat ^ 1);
            poked = 1'b1;
         end
         if (wait_left > 0) begin
            wait_left--;
            wbm.ack = 1'b0;
            wbm.err = 1'b0;
            @(negedge wb_clk);
            start = 1'b0;
            continue;
         end
         wbm.ack = 1'b1;
         wbm.err = (k == err_beat);
         @(negedge wb_clk);
         wbm.ack = 1'b0;
         wbm.err = 1'b0;
         start = 1'b0;
         if (k == err_beat) begin
            check_idle_bus("err_abort");
            check("err_flag", 64'(err), 64'd1);
            check("err_busy", 64'(busy), 64'd0);
            check("err_done", 64'(done), 64'd0);
            @(negedge wb_clk);
            check("err_sticky", 64'(err), 64'd1);
            check("err_idle_busy", 64'(busy), 64'd0);
            check("err_idle_done", 64'(done), 64'd0);
            check("err_idle_cyc", 64'(wbm.cyc), 64'd0);
            return;
         end
         k++;
         wait_left = $urandom_range(max_wait, 0);
         if (k == Total) begin
            check("done_pulse", 64'(done), 64'd1);
            check("done_busy", 64'(busy), 64'd0);
            check("done_err", 64'(err), 64'd0);
            check_idle_bus("done");
            @(negedge wb_clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
         end else if (k % BurstLen == 0) begin
            check("gap_cyc", 64'(wbm.cyc), 64'd0);
            check("gap_stb", 64'(wbm.stb), 64'd0);
            check("gap_busy", 64'(busy), 64'd1);
            check("gap_done", 64'(done), 64'd0);
            @(negedge wb_clk);
         end
      end
   endtask

   initial begin
      wbm.ack = 1'b0;
      wbm.err = 1'b0;
      repeat (3) @(negedge wb_clk);
      check_idle_bus("reset");
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      reset = 1'b0;
      @(negedge wb_clk);
      check("idle_no_start", 64'(wbm.cyc), 64'd0);

      run_frame(0, 0, -1, -1, 1'b0);
      run_frame(1, 0, -1, -1, 1'b0);
      run_frame(1, 5, -1, -1, 1'b0);
      run_frame(2, 3, -1, -1, 1'b0);
      run_frame(1, 2, 5, -1, 1'b0);
      run_frame(0, 1, -1, -1, 1'b0);
      run_frame(1, 1, -1, 9, 1'b1);
      run_frame(3, 2, -1, -1, 1'b0);
      run_frame(int'($urandom_range(3, 0)), 4, -1, -1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
